rr_arbiter_4: RTL and testbench
===============================

// Module: rr_arbiter_4
//
// PURPOSE
//   Round-robin arbiter placed directly upstream of the 4-to-2 encoder stage.
//   - Samples up to N request lines and issues one registered one-hot grant per transaction.
//   - Drives that grant as the encoder's one-hot input d[3:0].
//   - Holds each grant with a valid/ready handshake until the consumer accepts it.
//   - Guarantees the encoder never sees zero-hot or multi-hot input while gnt_vld=1.
//
// PARAMETERS
//   N        4   number of requesters; the one-hot grant width. Must be >=2. It is 4 when feeding the 4-to-2 encoder.
//   IDX_W    2   index width, equal to $clog2(N). Sizes the pointer and gnt_idx.
//
// PORTS
//   clk      in   1      single clock; all state updates on the rising edge
//   rst_n    in   1      asynchronous active-low reset
//   req      in   N      request vector; any number of bits may be set
//   gnt      out  N      registered one-hot grant; all zeros when gnt_vld=0
//   gnt_vld  out  1      grant valid
//   gnt_rdy  in   1      downstream accepts the grant
//   gnt_idx  out  IDX_W  binary index of gnt; present only with RR_ARB_IDX_EN
//
// BEHAVIOUR
//   - Reset (async assert, sync-to-clk deassert handled upstream):
//     - gnt=0, gnt_vld=0, gnt_idx=0, state=IDLE.
//     - ptr=N-1, so req[0] has first priority.
//   - FSM states and transitions:
//     - IDLE: if |req, load gnt from the pick of req (below), set gnt_vld=1, go to GRANT. Otherwise stay in IDLE.
//     - GRANT: hold gnt and gnt_vld stable while gnt_rdy=0, regardless of changes on req.
//   - Pick: the first set bit of req scanning circularly from ptr+1 upward, wrapping N-1 -> 0.
//   - Latency: 1 cycle from req sampled in IDLE to gnt_vld=1.
//   - Handshake: a transfer occurs on the rising edge where gnt_vld && gnt_rdy. On transfer:
//     - ptr <= index of the current gnt.
//     - If |req in that same cycle: load the next pick computed from the new ptr. The grant is back-to-back with no bubble, and the state stays GRANT.
//     - Else: gnt=0, gnt_vld=0, go to IDLE.
//   - Sticky grant: a requester that drops req while granted keeps its grant until the transfer.
//   - gnt_rdy while gnt_vld=0 is ignored.
//   - The pointer advances only on a transfer, never on a pick alone.
//   - Single requester: it is granted on every transaction. Round-robin never starves it.
//   - Reset mid-GRANT: outputs clear immediately (async) and the pending grant is dropped.
//
// CONFIGURATION
//   RR_ARB_IDX_EN
//     - Defined: adds the gnt_idx output port.
//       - Registered alongside gnt with identical timing.
//       - Encoding: gnt=0001->0, 0010->1, 0100->2, 1000->3.
//       - Holds its value while gnt_vld=0.
//     - Undefined: the port and its register are absent. Downstream encodes gnt itself.
//
// STRUCTURE
//   - Shared header rr_arb_defs.vh:
//     - State encodings RR_IDLE=1'b0, RR_GRANT=1'b1.
//     - Default N/IDX_W localparams.
//   - Sub-module rr_pick: purely combinational.
//     - Inputs: req[N-1:0], ptr[IDX_W-1:0].
//     - Outputs: one-hot pick[N-1:0], pick_idx[IDX_W-1:0], any.
//     - Implemented as rotate, fixed-priority select, rotate back.
//   - Top level holds the FSM, ptr, and output registers only.
//
// TESTING
//   1. Reset: rst_n=0 asserted mid-GRANT (gnt=0100) -> gnt=0 and gnt_vld=0 before the next edge. After release, req=1111 -> first gnt=0001.
//   2. Single request: req=0001, gnt_rdy=1 -> one cycle later gnt=0001, gnt_vld=1. Then req=0 -> next cycle gnt_vld=0, state IDLE.
//   3. Fairness: req=1111 held, gnt_rdy=1 held -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles with no bubbles.
//   4. Backpressure: req=0110, gnt_rdy=0 for 5 cycles -> gnt=0010 stable. Then req changes to 0100 -> still 0010. Then gnt_rdy=1 -> next cycle gnt=0100.
//   5. Wrap: after a transfer of 1000 (ptr=3), req=1001 -> next gnt=0001, not 1000.
//   6. With RR_ARB_IDX_EN: the step-3 sequence -> gnt_idx=0,1,2,3,0. Encoder y matches gnt_idx every valid cycle.

Source files
------------

// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the rr_arbiter_4 round-robin arbiter.
// Holds the FSM state encoding and the default sizing parameters.
// Optional feature macro used by the arbiter: RR_ARB_IDX_EN (adds gnt_idx output).
package rr_arbiter_4_pkg;

  // Default number of requesters (one-hot grant width) and its index width.
  localparam int unsigned RR_N_DEF     = 4;
  localparam int unsigned RR_IDX_W_DEF = 2;

  // Arbiter FSM states: IDLE waits for a request, GRANT holds a valid grant.
  typedef enum logic {
    RR_IDLE  = 1'b0,
    RR_GRANT = 1'b1
  } rr_state_e;

endpackage

// File: rtl/rr_arbiter_4_pick.sv
// Combinational round-robin pick for rr_arbiter_4.
// Returns the first set request scanning circularly upward from ptr+1.
// Done as: rotate req so bit ptr+1 lands at 0, take the lowest set bit,
// rotate the one-hot result back into place.
module rr_arbiter_4_pick
  import rr_arbiter_4_pkg::*;
#(
  parameter int unsigned N     = RR_N_DEF,
  parameter int unsigned IDX_W = RR_IDX_W_DEF
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  // One extra bit so the rotate amount ptr+1 can reach N without wrapping.
  localparam int unsigned SW = IDX_W + 1;

  logic [SW-1:0]  rot_amt;
  logic [SW-1:0]  back_amt;
  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] sel_dbl;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   sel_rot;

  // Rotate, fixed lowest-bit priority select, rotate back, then encode.
  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    rot_amt  = SW'({1'b0, ptr}) + SW'(1);
    back_amt = SW'(N) - rot_amt;
    req_dbl  = {req, req};
    req_rot  = N'(req_dbl >> rot_amt);
    sel_rot  = req_rot & (~req_rot + N'(1));
    sel_dbl  = {sel_rot, sel_rot};
    pick     = N'(sel_dbl >> back_amt);
    any      = |req;
    pick_idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (pick[i]) pick_idx = pick_idx | IDX_W'(i);
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter feeding the 4-to-2 encoder stage.
// Issues one registered one-hot grant per transaction and holds it under a
// valid/ready handshake; the pointer advances only when a grant transfers.
// Optional feature: define RR_ARB_IDX_EN to add the registered gnt_idx output.
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int unsigned N     = RR_N_DEF,
  parameter int unsigned IDX_W = RR_IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic             gnt_vld,
  input  logic             gnt_rdy
`ifdef RR_ARB_IDX_EN
  ,
  output logic [IDX_W-1:0] gnt_idx
`endif
);

  rr_state_e        state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] pick_ptr;
  logic [N-1:0]     pick;
  logic [IDX_W-1:0] pick_idx;
  logic             any;

`ifdef RR_ARB_IDX_EN
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;

  // The registered index already names the current grant.
  assign cur_idx = gnt_idx_q;
  assign gnt_idx = gnt_idx_q;
`else
  logic unused_pick_idx;

  assign unused_pick_idx = ^pick_idx;

  // Binary index of the held grant, needed to advance the pointer.
  always_comb begin
    cur_idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (gnt_q[i]) cur_idx = cur_idx | IDX_W'(i);
    end
  end
`endif

  // While granting, the next pick is taken from the pointer the transfer
  // will install (the current grant index), giving back-to-back grants.
  assign pick_ptr = (state_q == RR_GRANT) ? cur_idx : ptr_q;

  rr_arbiter_4_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req      (req),
    .ptr      (pick_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any)
  );

  // Next-state logic: load a pick from IDLE, hold under backpressure,
  // and on transfer either reload back-to-back or fall back to IDLE.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
`ifdef RR_ARB_IDX_EN
    gnt_idx_d = gnt_idx_q;
`endif
    case (state_q)
      RR_IDLE: begin
        if (any) begin
          gnt_d     = pick;
`ifdef RR_ARB_IDX_EN
          gnt_idx_d = pick_idx;
`endif
          state_d   = RR_GRANT;
        end
      end
      RR_GRANT: begin
        if (gnt_rdy) begin
          ptr_d = cur_idx;
          if (any) begin
            gnt_d     = pick;
`ifdef RR_ARB_IDX_EN
            gnt_idx_d = pick_idx;
`endif
          end else begin
            gnt_d   = '0;
            state_d = RR_IDLE;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = RR_IDLE;
      end
    endcase
  end

  // State, pointer and output registers; reset gives req[0] first priority.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RR_IDLE;
      ptr_q     <= IDX_W'(N - 1);
      gnt_q     <= '0;
`ifdef RR_ARB_IDX_EN
      gnt_idx_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
`ifdef RR_ARB_IDX_EN
      gnt_idx_q <= gnt_idx_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = (state_q == RR_GRANT);

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed scenarios plus a randomized
// run, all compared against a behavioural round-robin model.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_vld;
  logic       gnt_rdy;
`ifdef RR_ARB_IDX_EN
  logic [1:0] gnt_idx;
`endif

  int errors = 0;
  int checks = 0;

  // Behavioural model: is a grant held, which requester holds it, pointer.
  int m_vld;
  int m_idx;
  int m_ptr;

  rr_arbiter_4 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_rdy (gnt_rdy)
`ifdef RR_ARB_IDX_EN
    ,
    .gnt_idx (gnt_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, required run to finish");
    $fatal(1);
  end

  // Circular scan starting just above the pointer.
  function automatic int model_pick(input int ptr, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_gnt();
    logic [3:0] g;
    g = '0;
    if (m_vld != 0) g[m_idx] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_vld = 0;
    m_idx = 0;
    m_ptr = 3;
  endtask

  task automatic model_step(input logic [3:0] r, input logic rdy);
    if (m_vld == 0) begin
      if (r != 0) begin
        m_idx = model_pick(m_ptr, r);
        m_vld = 1;
      end
    end else if (rdy) begin
      m_ptr = m_idx;
      if (r != 0) m_idx = model_pick(m_ptr, r);
      else        m_vld = 0;
    end
  endtask

  // Drive inputs at the falling edge, model the rising edge, return at the
  // next falling edge so outputs are sampled away from the active edge.
  task automatic tick(input logic [3:0] r, input logic rdy);
    req     = r;
    gnt_rdy = rdy;
    @(posedge clk);
    model_step(r, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    req     = '0;
    gnt_rdy = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: gnt=%b vld=%b, required gnt=0000 vld=0", gnt, gnt_vld);
    end
`ifdef RR_ARB_IDX_EN
    checks++;
    if (gnt_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_idx: gnt_idx=%0d, required 0", gnt_idx);
    end
`endif
    rst_n = 1'b1;
    tick(4'b0100, 1'b0);
    checks++;
    if (gnt !== 4'b0100 || gnt_vld !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_grant: gnt=%b vld=%b, required gnt=0100 vld=1", gnt, gnt_vld);
    end
    // Assert reset between edges: outputs must clear before the next edge.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: gnt=%b vld=%b, required gnt=0000 vld=0", gnt, gnt_vld);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(4'b1111, 1'b0);
    checks++;
    if (gnt !== 4'b0001 || gnt_vld !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_pick: gnt=%b vld=%b, required gnt=0001 vld=1", gnt, gnt_vld);
    end
  endtask

  task automatic test_single();
    tick(4'b0000, 1'b1);
    checks++;
    if (gnt_vld !== 1'b0 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL single_drain: gnt=%b vld=%b, required gnt=0000 vld=0", gnt, gnt_vld);
    end
    // Single requester granted on every transaction.
    for (int n = 0; n < 3; n++) begin
      tick(4'b0001, 1'b1);
      checks++;
      if (gnt !== 4'b0001 || gnt_vld !== 1'b1) begin
        errors++;
        $display("FAIL single_grant[%0d]: gnt=%b vld=%b, required gnt=0001 vld=1", n, gnt, gnt_vld);
      end
    end
    tick(4'b0000, 1'b1);
    checks++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
      errors++;
      $display("FAIL single_release: gnt=%b vld=%b, required gnt=0000 vld=0", gnt, gnt_vld);
    end
`ifdef RR_ARB_IDX_EN
    checks++;
    if (gnt_idx !== 2'd0) begin
      errors++;
      $display("FAIL single_idx_hold: gnt_idx=%0d, required 0", gnt_idx);
    end
`endif
  endtask

  task automatic test_fairness();
    logic [3:0] seq [5];
    seq[0] = 4'b0001;
    seq[1] = 4'b0010;
    seq[2] = 4'b0100;
    seq[3] = 4'b1000;
    seq[4] = 4'b0001;
    do_reset();
    for (int n = 0; n < 5; n++) begin
      tick(4'b1111, 1'b1);
      checks++;
      if (gnt !== seq[n] || gnt_vld !== 1'b1) begin
        errors++;
        $display("FAIL fairness[%0d]: gnt=%b vld=%b, required gnt=%b vld=1", n, gnt, gnt_vld, seq[n]);
      end
`ifdef RR_ARB_IDX_EN
      checks++;
      if (gnt_idx !== 2'(n % 4)) begin
        errors++;
        $display("FAIL fairness_idx[%0d]: gnt_idx=%0d, required %0d", n, gnt_idx, n % 4);
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    tick(4'b0000, 1'b1);
    for (int n = 0; n < 5; n++) begin
      tick(4'b0110, 1'b0);
      checks++;
      if (gnt !== 4'b0010 || gnt_vld !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: gnt=%b vld=%b, required gnt=0010 vld=1", n, gnt, gnt_vld);
      end
    end
    // Requester 1 drops its request; its grant must stick.
    tick(4'b0100, 1'b0);
    checks++;
    if (gnt !== 4'b0010 || gnt_vld !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_sticky: gnt=%b vld=%b, required gnt=0010 vld=1", gnt, gnt_vld);
    end
    tick(4'b0100, 1'b1);
    checks++;
    if (gnt !== 4'b0100 || gnt_vld !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: gnt=%b vld=%b, required gnt=0100 vld=1", gnt, gnt_vld);
    end
  endtask

  task automatic test_wrap();
    tick(4'b1000, 1'b1);
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_setup: gnt=%b, required 1000", gnt);
    end
    tick(4'b1001, 1'b1);
    checks++;
    if (gnt !== 4'b0001 || gnt_vld !== 1'b1) begin
      errors++;
      $display("FAIL wrap_pick: gnt=%b vld=%b, required gnt=0001 vld=1", gnt, gnt_vld);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       rdy;
    for (int n = 0; n < 400; n++) begin
      r   = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 2) != 0);
      tick(r, rdy);
      checks++;
      if (gnt !== exp_gnt() || gnt_vld !== (m_vld != 0)) begin
        errors++;
        $display("FAIL random[%0d]: gnt=%b vld=%b, required gnt=%b vld=%0d", n, gnt, gnt_vld, exp_gnt(), m_vld);
      end
`ifdef RR_ARB_IDX_EN
      checks++;
      if (gnt_idx !== 2'(m_idx)) begin
        errors++;
        $display("FAIL random_idx[%0d]: gnt_idx=%0d, required %0d", n, gnt_idx, m_idx);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
